// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_INSTR_W = 32;
   localparam int unsigned PC_STEP     = 4;

   // Decode treats an all-zero word as a NOP.
   localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]  pc;
      logic [DEF_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries ahead of decode.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned  DEPTH   = 2,
   parameter type          entry_t = fetch_entry_t,
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           pop_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign count    = count_q;
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem_q[rd_ptr_q];

   // Pointers and occupancy; flush wins over a push at the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Entry storage has no reset; occupancy alone says which slots are live.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers responses and feeds the decode-facing output register.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       INSTR_W  = DEF_INSTR_W,
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_next
);

   localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0]    CREDITS = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  resp_pc_q;
   logic [CNT_W-1:0]   outstanding_q;
   logic [CNT_W-1:0]   outstanding_d;
   logic [CNT_W-1:0]   drop_q;
   logic               if_valid_q;
   logic [INSTR_W-1:0] if_instr_q;
   logic [ADDR_W-1:0]  if_pc_q;
   logic [ADDR_W-1:0]  if_pc_next_q;

   logic [ADDR_W-1:0]  target_aligned;
   logic               unused_target_lsb;
   logic [CNT_W:0]     in_use;
   logic               req_fire;
   logic               out_load;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_empty;
   logic               fifo_full;
   logic [CNT_W-1:0]   fifo_count;
   entry_t             fifo_in;
   entry_t             fifo_head;

   assign target_aligned    = {branch_target[ADDR_W-1:2], 2'b00};
   assign unused_target_lsb = ^branch_target[1:0];

   // Output register may take a new entry when decode is not holding a real one.
   assign out_load = !freeze || !if_valid_q;
   assign fifo_pop = !branch_taken && out_load && !fifo_empty;

   // Slots committed = in flight + buffered; a pop this cycle frees one slot,
   // which is what sustains one fetch per cycle at single-cycle memory latency.
   assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, fifo_pop};

   assign imem_req_valid = rst_n && !branch_taken && (in_use < CREDITS);
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses are discarded while stale fetches drain, and in the redirect cycle.
   assign fifo_push     = imem_rsp_valid && (drop_q == '0) && !branch_taken && !fifo_full;
   assign fifo_in.pc    = resp_pc_q;
   assign fifo_in.instr = imem_rsp_data;

   assign outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (branch_taken),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // PC, in-flight count, stale-response drop count and response tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         if (branch_taken) begin
            pc_q      <= target_aligned;
            resp_pc_q <= target_aligned;
            // Everything still in flight after this cycle belongs to the old path.
            drop_q    <= outstanding_d;
         end else begin
            if (req_fire)  pc_q      <= pc_q + STEP;
            if (fifo_push) resp_pc_q <= resp_pc_q + STEP;
            if (imem_rsp_valid && (drop_q != '0)) drop_q <= drop_q - CNT_W'(1);
         end
      end
   end

   // Decode-facing register: flushed by redirect, held by freeze, else refilled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_q   <= 1'b0;
         if_instr_q   <= INSTR_W'(NOP_INSTR);
         if_pc_q      <= '0;
         if_pc_next_q <= '0;
      end else if (branch_taken) begin
         if_valid_q <= 1'b0;
      end else if (fifo_pop) begin
         if_valid_q   <= 1'b1;
         if_instr_q   <= fifo_head.instr;
         if_pc_q      <= fifo_head.pc;
         if_pc_next_q <= fifo_head.pc + STEP;
      end else if (out_load) begin
         if_valid_q <= 1'b0;
      end
   end

   assign if_valid   = if_valid_q;
   assign if_instr   = if_instr_q;
   assign if_pc      = if_pc_q;
   assign if_pc_next = if_pc_next_q;

endmodule
